hazard_redirect_ctrl: RTL
=========================

// Module: hazard_redirect_ctrl
// PURPOSE
//  Consumer end of the branch/jump/load control pipeline: takes the latched Branch, Jump, MemtoReg
//  flags plus register IDs and decides stall, flush and PC redirect for the 5-stage CPU.
//  Drives write enables of PC and IF/ID, flush inputs of IF/ID, ID/EX and EX/MEM, and the PC mux.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  ADDR_W      32  PC / target address width
//  REG_W       5   register-index width
//  STALL_CYC   1   load-use bubble length in cycles (>=1)
//  CNT_W       16  width of each event counter
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst           in   1       synchronous, active-high reset
//  id_rs         in   REG_W   source reg 1 of instruction in ID
//  id_rt         in   REG_W   source reg 2 of instruction in ID
//  ex_rt         in   REG_W   destination reg of instruction in EX
//  ex_MemtoReg   in   1       instruction in EX is a load
//  mem_Branch    in   1       latched Branch flag, instruction in MEM
//  mem_Jump      in   1       latched Jump flag, instruction in MEM
//  mem_Zero      in   1       latched ALU zero, instruction in MEM
//  branch_target in   ADDR_W  latched branch target
//  jump_target   in   ADDR_W  latched jump target
//  pc_write      out  1       PC register load enable
//  ifid_write    out  1       IF/ID load enable
//  ifid_flush    out  1       clear IF/ID to NOP
//  idex_flush    out  1       clear ID/EX to NOP
//  exmem_flush   out  1       clear EX/MEM to NOP
//  pc_sel        out  2       00 seq, 01 branch, 10 jump
//  redirect_pc   out  ADDR_W  selected target; 0 when pc_sel=00
//  stall_cnt     out  CNT_W   cycles spent in load-use stall, saturating
//  flush_cnt     out  CNT_W   redirects taken, saturating
// BEHAVIOUR
//  States: RUN, STALL. State, stall counter and event counters are registered.
//  Outputs are combinational from state and current inputs.
//  rst high: next state RUN, counters 0. Same cycle: pc_write=0, ifid_write=0,
//   all three flushes=1, pc_sel=00, redirect_pc=0.
//  Idle RUN outputs: pc_write=1, ifid_write=1, flushes=0, pc_sel=00.
//  redirect = mem_Jump | (mem_Branch & mem_Zero).
//   Jump wins when both are set: pc_sel=10, redirect_pc=jump_target.
//   Otherwise pc_sel=01, redirect_pc=branch_target.
//  hazard = ex_MemtoReg & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//  Priority: rst > redirect > hazard.
//  Redirect, any state, this cycle: pc_write=1, ifid_write=1, ifid/idex/exmem_flush=1,
//   flush_cnt+1. Next state RUN; any pending stall is aborted.
//  Hazard in RUN (no redirect): pc_write=0, ifid_write=0, idex_flush=1, stall_cnt+1.
//   STALL_CYC==1: stay in RUN.
//   STALL_CYC>1: enter STALL with remaining=STALL_CYC-1.
//  STALL: same outputs as a hazard cycle, stall_cnt+1, remaining-1; at 1 -> RUN.
//   Inputs other than redirect are ignored in STALL.
//  Latency: zero-cycle decision. The bubble is visible in ID/EX the edge after detection.
//  Counters saturate at all-ones and never wrap.
//  rst mid-STALL: next cycle RUN, remaining cleared.
// STRUCTURE
//  Shared pkg: PC_SEL_SEQ/BR/JMP localparams, state encoding RUN=0/STALL=1.
//  Sub-module: sat_counter (CNT_W, inc, rst), instantiated twice.
//  Top holds the FSM and output decode.
// TESTING
//  1. Load r5 in EX, ID uses rs=5 -> one cycle: pc_write=0, ifid_write=0, idex_flush=1;
//     stall_cnt=1 next.
//  2. ex_rt=0, ex_MemtoReg=1, id_rs=0 -> no stall; pc_write=1.
//  3. mem_Branch=1, mem_Zero=1, branch_target=0x40 -> pc_sel=01, redirect_pc=0x40,
//     three flushes=1; flush_cnt=1.
//  4. mem_Branch=1, mem_Jump=1, jump_target=0x80 -> pc_sel=10, redirect_pc=0x80.
//  5. STALL_CYC=3, hazard, then redirect in 2nd stall cycle -> redirect outputs that cycle;
//     RUN next; stall_cnt=2.
//  6. rst asserted mid-STALL -> flushes=1 that cycle; RUN and counters 0 next;
//     also force stall_cnt to all-ones and check it saturates.

Source files
------------

// File: rtl/hazard_redirect_ctrl_pkg.sv
// Shared definitions for the hazard/redirect controller: PC mux encodings, FSM states
// and the bundle of pipeline control strobes that the top decodes every cycle.
package hazard_redirect_ctrl_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } ctrlState_t;

  typedef struct packed {
    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexFlush;
    logic       exmemFlush;
    logic [1:0] pcSel;
  } ctrlBundle_t;

  // Canonical strobe patterns; the redirect pattern gets its pcSel filled in by the top.
  localparam ctrlBundle_t CTRL_IDLE = '{
    pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b0,
    exmemFlush: 1'b0, pcSel: PC_SEL_SEQ
  };

  localparam ctrlBundle_t CTRL_RESET = '{
    pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b1, idexFlush: 1'b1,
    exmemFlush: 1'b1, pcSel: PC_SEL_SEQ
  };

  localparam ctrlBundle_t CTRL_BUBBLE = '{
    pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0, idexFlush: 1'b1,
    exmemFlush: 1'b0, pcSel: PC_SEL_SEQ
  };

  localparam ctrlBundle_t CTRL_REDIRECT = '{
    pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b1, idexFlush: 1'b1,
    exmemFlush: 1'b1, pcSel: PC_SEL_SEQ
  };

endpackage

// File: rtl/hazard_redirect_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, synchronous clear on rst.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Stall / flush / PC-redirect decision for the 5-stage pipeline, with a multi-cycle
// load-use bubble FSM and saturating stall and flush event counters.
module hazard_redirect_ctrl
  import hazard_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 5,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              ex_MemtoReg,
  input  logic              mem_Branch,
  input  logic              mem_Jump,
  input  logic              mem_Zero,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Holds at most STALL_CYC-1; one bit is kept even when the bubble is single-cycle.
  localparam int REM_W = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;

  ctrlState_t       state, nextState;
  logic [REM_W-1:0] remaining, nextRemaining;
  ctrlBundle_t      ctrl;
  logic             redirect, hazard, stallInc, flushInc;

  assign redirect = mem_Jump | (mem_Branch & mem_Zero);
  assign hazard   = ex_MemtoReg && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      remaining <= '0;
    end else begin
      state     <= nextState;
      remaining <= nextRemaining;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl          = CTRL_IDLE;
    redirect_pc   = '0;
    nextState     = state;
    nextRemaining = remaining;
    stallInc      = 1'b0;
    flushInc      = 1'b0;

    if (rst) begin
      ctrl          = CTRL_RESET;
      nextState     = RUN;
      nextRemaining = '0;
    end else if (redirect) begin
      // A taken redirect squashes the wrong-path work, so any pending bubble is moot.
      ctrl          = CTRL_REDIRECT;
      flushInc      = 1'b1;
      nextState     = RUN;
      nextRemaining = '0;
      if (mem_Jump) begin
        ctrl.pcSel  = PC_SEL_JMP;
        redirect_pc = jump_target;
      end else begin
        ctrl.pcSel  = PC_SEL_BR;
        redirect_pc = branch_target;
      end
    end else if (state == STALL) begin
      ctrl     = CTRL_BUBBLE;
      stallInc = 1'b1;
      if (remaining <= REM_W'(1)) begin
        nextState     = RUN;
        nextRemaining = '0;
      end else begin
        nextRemaining = remaining - 1'b1;
      end
    end else if (hazard) begin
      ctrl     = CTRL_BUBBLE;
      stallInc = 1'b1;
      if (STALL_CYC > 1) begin
        nextState     = STALL;
        nextRemaining = REM_W'(STALL_CYC - 1);
      end
    end
  end

  assign pc_write    = ctrl.pcWrite;
  assign ifid_write  = ctrl.ifidWrite;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_flush  = ctrl.idexFlush;
  assign exmem_flush = ctrl.exmemFlush;
  assign pc_sel      = ctrl.pcSel;

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushInc),
    .count (flush_cnt)
  );

endmodule
